// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-and-add multiplier, one multiplier bit per cycle.
// Define SEQ_MULT_SIGNED_EN for two's complement operands.
module seq_shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state_q;
  logic [PW-1:0]   a_q;
  logic [PW-1:0]   acc_q;
  logic [PW-1:0]   prod_q;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]   cnt_q;

  logic [PW-1:0]   a_ext;
  logic [PW-1:0]   addend;
  logic [PW-1:0]   acc_d;
  logic            last;

  always_comb begin
`ifdef SEQ_MULT_SIGNED_EN
    a_ext = {{WIDTH{a[WIDTH-1]}}, a};
`else
    a_ext = {{WIDTH{1'b0}}, a};
`endif
    last   = (cnt_q == CW'(WIDTH - 1));
    addend = b_q[cnt_q] ? (a_q << cnt_q) : '0;
`ifdef SEQ_MULT_SIGNED_EN
    // MSB of a two's complement multiplier carries negative weight
    acc_d  = last ? (acc_q - addend) : (acc_q + addend);
`else
    acc_d  = acc_q + addend;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a_ext;
            b_q     <= b;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            prod_q  <= acc_d;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign product   = prod_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench for seq_shift_add_multiplier at WIDTH=4.
// Honours SEQ_MULT_SIGNED_EN for the reference model.
module tb_seq_shift_add_multiplier;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic           busy;

  int nchecks = 0;
  int nerr    = 0;
  logic [2*W-1:0] last_prod;

  seq_shift_add_multiplier #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] ref_mul(logic [W-1:0] x, logic [W-1:0] y);
    int p;
`ifdef SEQ_MULT_SIGNED_EN
    p = int'($signed(x)) * int'($signed(y));
`else
    p = int'(x) * int'(y);
`endif
    return p[2*W-1:0];
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_prod = '0;
  endtask

  // Full transaction; hold = cycles of out_ready low in DONE.
  // glitch = 1 disturbs the inputs during RUN.
  task automatic do_op(logic [W-1:0] ta, logic [W-1:0] tbv,
                       int hold, bit glitch, logic [2*W-1:0] exp);
    int cyc;
    int busy_cyc;
    @(negedge clk);
    check("ready_before", in_ready, 1'b1);
    a = ta;
    b = tbv;
    in_valid = 1'b1;
    out_ready = (hold == 0);
    @(negedge clk);
    in_valid = 1'b0;
    check("busy_after_accept", busy, 1'b1);
    check("ready_low_run", in_ready, 1'b0);
    check("prod_kept_run", product, last_prod);
    cyc = 1;
    busy_cyc = 1;
    while (!out_valid && cyc < 50) begin
      if (glitch && cyc == 2) begin
        a = ~ta;
        b = ~tbv;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
      if (busy) busy_cyc++;
    end
    in_valid = 1'b0;
    // accept edge counts as edge 1: out_valid at edge W+1
    check("latency", cyc, W + 1);
    check("busy_cycles", busy_cyc, W);
    check("product", product, exp);
    check("busy_done", busy, 1'b0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      @(negedge clk);
      check("hold_valid", out_valid, 1'b1);
      check("hold_prod", product, exp);
      check("hold_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("retire_ready", in_ready, 1'b1);
    check("retire_valid", out_valid, 1'b0);
    check("retire_prod", product, exp);
    last_prod = exp;
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    last_prod = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", in_ready, 1'b1);
    check("rst_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_prod", product, 8'h00);
    rst = 1'b0;

`ifdef SEQ_MULT_SIGNED_EN
    do_op(4'h8, 4'h8, 0, 1'b0, 8'h40);
    do_op(4'h8, 4'h7, 0, 1'b0, 8'hC8);
    do_op(4'h7, 4'hF, 0, 1'b0, 8'hF9);
`else
    do_op(4'hF, 4'hF, 0, 1'b0, 8'hE1);
    do_op(4'h0, 4'h9, 0, 1'b0, 8'h00);
    do_op(4'hF, 4'h1, 0, 1'b0, 8'h0F);
`endif
    do_op(4'h3, 4'h5, 10, 1'b0, 8'h0F);
    do_op(4'h6, 4'h3, 0, 1'b0, ref_mul(4'h6, 4'h3));
    do_op(4'h3, 4'h5, 0, 1'b1, 8'h0F);

    // Abort in RUN cycle 3
    @(negedge clk);
    a = 4'h3;
    b = 4'h5;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_busy", busy, 1'b1);
    rst = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("abort_ready", in_ready, 1'b1);
    check("abort_busy_low", busy, 1'b0);
    check("abort_prod", product, 8'h00);
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      check("abort_no_valid", out_valid, 1'b0);
    end
    last_prod = '0;

    // Abort while holding a result in DONE
    do_op(4'h2, 4'h3, 2, 1'b0, ref_mul(4'h2, 4'h3));
    @(negedge clk);
    a = 4'h5;
    b = 4'h5;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (W) @(negedge clk);
    check("done_before_rst", out_valid, 1'b1);
    rst = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b0;
    check("done_rst_ready", in_ready, 1'b1);
    check("done_rst_valid", out_valid, 1'b0);
    check("done_rst_prod", product, 8'h00);
    last_prod = '0;

    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      do_op(ra, rb, int'($urandom_range(0, 3)), 1'(i % 3 == 0),
            ref_mul(ra, rb));
    end

    do_reset();
    check("final_ready", in_ready, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule

// File: doc/seq_shift_add_multiplier.md
SEQ_SHIFT_ADD_MULTIPLIER -- requirements
Module: seq_shift_add_multiplier

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, operand width in bits; legal values are 2 to 32.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 Port clk SHALL be an input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit: synchronous, active-high reset.
REQ-005 Port in_valid SHALL be an input, 1 bit: the operands on a and b are valid.
REQ-006 Port in_ready SHALL be an output, 1 bit: the block can accept operands.
REQ-007 Port a SHALL be an input, WIDTH bits: the multiplicand.
REQ-008 Port b SHALL be an input, WIDTH bits: the multiplier.
REQ-009 Port out_valid SHALL be an output, 1 bit: product holds a completed result.
REQ-010 Port out_ready SHALL be an input, 1 bit: the consumer accepts the result.
REQ-011 Port product SHALL be an output, 2*WIDTH bits: the result, registered.
REQ-012 Port busy SHALL be an output, 1 bit: high while the block is in RUN.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-014 in_ready SHALL equal (state==IDLE).
REQ-015 busy SHALL equal (state==RUN).
REQ-016 out_valid SHALL equal (state==DONE).
REQ-017 When in_valid & in_ready at an edge, the block SHALL capture a and b, clear the accumulator, zero the bit counter and enter RUN.
REQ-018 In RUN, each cycle SHALL examine one bit of the captured b, LSB first; if that bit is 1, (a << bit index), extended to 2*WIDTH, SHALL be added to the accumulator modulo 2^(2*WIDTH).
REQ-019 RUN SHALL last exactly WIDTH cycles, regardless of operand values; there is no early termination for zero or small operands.
REQ-020 After the last RUN cycle the block SHALL enter DONE with product = final accumulator, so out_valid rises WIDTH+1 edges after the accepting edge.
REQ-021 In DONE, product and out_valid SHALL hold stable until out_ready is sampled high; the block then returns to IDLE.
REQ-022 A new acceptance SHALL NOT occur in the same cycle as result retirement, because in_ready is low in DONE.
REQ-023 in_valid while in RUN or DONE SHALL be ignored; operand changes during RUN SHALL NOT affect the result.
REQ-024 product SHALL be updated only on entry to DONE, and SHALL retain its last result while in IDLE and RUN.
REQ-025 With the macro absent, the result SHALL be the exact unsigned product; the maximum, (2^WIDTH-1)^2, fits in 2*WIDTH bits.

Reset
REQ-026 rst sampled high SHALL force state=IDLE, product=0, accumulator=0 and counter=0.
REQ-027 After reset, in_ready SHALL be 1, and out_valid and busy SHALL be 0.
REQ-028 rst asserted during RUN or DONE SHALL abort the operation; no result is produced and in_ready=1 on the following cycle.
REQ-029 rst SHALL take priority over the in_valid and out_ready handshakes sampled in the same cycle.

Configuration
REQ-030 Macro SEQ_MULT_SIGNED_EN SHALL select the operand format.
REQ-031 With SEQ_MULT_SIGNED_EN defined, a and b SHALL be two's complement: a is sign-extended to 2*WIDTH before shifting, and the MSB iteration of b SUBTRACTS the shifted a. The product is the exact signed result; latency is unchanged.
REQ-032 With SEQ_MULT_SIGNED_EN undefined, operands SHALL be unsigned and every iteration adds, per REQ-018.
REQ-033 All interface timing SHALL be identical in both configurations.

Verification (WIDTH=4)
REQ-034 Unsigned build: a=15, b=15, out_ready=1 -> out_valid high 5 edges after acceptance, product=8'hE1, then in_ready=1.
REQ-035 Unsigned build: a=0, b=9 -> product=8'h00 with the same 5-edge latency as any other operands.
REQ-036 Signed build: a=-8, b=-8 -> product=8'h40; a=-8, b=7 -> product=8'hC8; a=7, b=-1 -> product=8'hF9.
REQ-037 Backpressure: out_ready=0 for 10 cycles in DONE -> product and out_valid stable and in_ready=0; out_ready=1 -> IDLE next edge.
REQ-038 a=3, b=5 accepted; at RUN cycle 2, change a/b and pulse in_valid -> ignored, product=8'h0F; assert rst in RUN cycle 3 -> IDLE, product=0, no out_valid.
